// File: rtl/parc_core_reorder_buffer_if.sv
// Issue, writeback, commit and bypass signal bundle of the PARC reorder buffer.
// The ROB takes the slave modport; issue/writeback/commit consumers take master.
interface parc_core_reorder_buffer_if;
  // Alloc handshake: a slot is granted at the posedge where val && rdy are both 1.
  // rdy never depends on val; val may be held or dropped freely while rdy is 0.
  logic        rob_alloc_req_val;
  logic        rob_alloc_req_rdy;
  logic [4:0]  rob_alloc_req_preg;
  logic [3:0]  rob_alloc_resp_slot;

  logic        rob_fill_val;
  logic [3:0]  rob_fill_slot;
  logic [31:0] rob_fill_data;

  logic        rob_commit_wen;
  logic [3:0]  rob_commit_slot;
  logic [4:0]  rob_commit_rf_waddr;
  logic [31:0] rob_commit_rf_wdata;

  logic [3:0]  rob_src0_byp_slot;
  logic [3:0]  rob_src1_byp_slot;
  logic [31:0] rob_src0_byp_data;
  logic [31:0] rob_src1_byp_data;

  modport master (
    output rob_alloc_req_val, rob_alloc_req_preg,
    output rob_fill_val, rob_fill_slot, rob_fill_data,
    output rob_src0_byp_slot, rob_src1_byp_slot,
    input  rob_alloc_req_rdy, rob_alloc_resp_slot,
    input  rob_commit_wen, rob_commit_slot, rob_commit_rf_waddr, rob_commit_rf_wdata,
    input  rob_src0_byp_data, rob_src1_byp_data
  );

  modport slave (
    input  rob_alloc_req_val, rob_alloc_req_preg,
    input  rob_fill_val, rob_fill_slot, rob_fill_data,
    input  rob_src0_byp_slot, rob_src1_byp_slot,
    output rob_alloc_req_rdy, rob_alloc_resp_slot,
    output rob_commit_wen, rob_commit_slot, rob_commit_rf_waddr, rob_commit_rf_wdata,
    output rob_src0_byp_data, rob_src1_byp_data
  );
endinterface

// File: rtl/parc_core_reorder_buffer.sv
// 16-entry in-order reorder buffer: allocate at tail, fill out of order,
// commit from head in program order, plus two bypass read ports.
module parc_core_reorder_buffer (
  input  logic                        clk,
  input  logic                        reset,
  parc_core_reorder_buffer_if.slave   rob
);

  logic [15:0] r_valid;
  logic [15:0] r_ready;
  logic [4:0]  r_preg [16];
  logic [31:0] r_data [16];
  logic [3:0]  r_head;
  logic [3:0]  r_tail;
  logic [4:0]  r_count;

  logic w_alloc_rdy;
  logic w_alloc;
  logic w_fill;
  logic w_commit;

  // rdy looks only at the registered count, so a full ROB refuses alloc even
  // in a cycle where the head retires.
  assign w_alloc_rdy = reset && (r_count != 5'd16);
  assign w_alloc     = rob.rob_alloc_req_val && w_alloc_rdy;
  assign w_fill      = rob.rob_fill_val && r_valid[rob.rob_fill_slot] &&
                       !(w_alloc && (rob.rob_fill_slot == r_tail));
  assign w_commit    = r_valid[r_head] && r_ready[r_head];

  assign rob.rob_alloc_req_rdy   = w_alloc_rdy;
  assign rob.rob_alloc_resp_slot = r_tail;

  assign rob.rob_commit_wen      = w_commit;
  assign rob.rob_commit_slot     = r_head;
  assign rob.rob_commit_rf_waddr = r_preg[r_head];
  assign rob.rob_commit_rf_wdata = r_data[r_head];

  assign rob.rob_src0_byp_data   = r_data[rob.rob_src0_byp_slot];
  assign rob.rob_src1_byp_data   = r_data[rob.rob_src1_byp_slot];

  // Statement order gives priority: commit clears after fill, alloc overrides both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_ready <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < 16; i++) begin
        r_preg[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_fill) begin
        r_ready[rob.rob_fill_slot] <= 1'b1;
        r_data[rob.rob_fill_slot]  <= rob.rob_fill_data;
      end
      if (w_commit) begin
        r_valid[r_head] <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_head          <= r_head + 4'd1;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_ready[r_tail] <= 1'b0;
        r_preg[r_tail]  <= rob.rob_alloc_req_preg;
        r_tail          <= r_tail + 4'd1;
      end
      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_parc_core_reorder_buffer.sv
// Scoreboard bench for parc_core_reorder_buffer: program-order queue model,
// directed scenarios followed by randomized alloc/fill traffic.
module tb_parc_core_reorder_buffer;

  logic clk;
  logic rst_n;

  parc_core_reorder_buffer_if rob_if ();

  parc_core_reorder_buffer dut (
    .clk   (clk),
    .reset (rst_n),
    .rob   (rob_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model / scoreboard state ----------------
  logic [8:0]  exp_q[$];          // {slot, preg} in program order
  bit          filled   [16];
  logic [31:0] mem_data [16];
  logic [3:0]  m_tail;
  bit          mon_en;
  int          n_checks;
  int          n_errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_tail = '0;
    for (int i = 0; i < 16; i++) begin
      filled[i]   = 1'b0;
      mem_data[i] = '0;
    end
  endtask

  function automatic bit in_q(input logic [3:0] s);
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i][8:5] == s) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      logic [8:0] e;
      bit exp_wen;
      exp_wen = (exp_q.size() > 0) && filled[exp_q[0][8:5]];
      chk("commit_wen", {31'd0, rob_if.rob_commit_wen}, {31'd0, exp_wen});
      if (rob_if.rob_commit_wen) begin
        if (exp_q.size() == 0) begin
          chk("commit_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("commit_slot",  {28'd0, rob_if.rob_commit_slot},     {28'd0, e[8:5]});
          chk("commit_waddr", {27'd0, rob_if.rob_commit_rf_waddr}, {27'd0, e[4:0]});
          chk("commit_wdata", rob_if.rob_commit_rf_wdata,          mem_data[e[8:5]]);
        end
      end
      chk("byp0_data", rob_if.rob_src0_byp_data, mem_data[rob_if.rob_src0_byp_slot]);
      chk("byp1_data", rob_if.rob_src1_byp_data, mem_data[rob_if.rob_src1_byp_slot]);
    end
  end

  // ---------------- driver ----------------
  // Called just after a posedge; returns just after the next posedge with the model updated.
  task automatic step(input bit a, input logic [4:0] p, input bit f,
                      input logic [3:0] fs, input logic [31:0] fd, input int b0 = -1);
    bit exp_rdy;
    bit fill_ok;
    exp_rdy = (exp_q.size() != 16);
    fill_ok = f && in_q(fs);
    chk("alloc_rdy",  {31'd0, rob_if.rob_alloc_req_rdy},   {31'd0, exp_rdy});
    chk("resp_slot",  {28'd0, rob_if.rob_alloc_resp_slot}, {28'd0, m_tail});
    rob_if.rob_alloc_req_val  = a;
    rob_if.rob_alloc_req_preg = p;
    rob_if.rob_fill_val       = f;
    rob_if.rob_fill_slot      = fs;
    rob_if.rob_fill_data      = fd;
    rob_if.rob_src0_byp_slot  = (b0 < 0) ? 4'($urandom_range(0, 15)) : 4'(b0);
    rob_if.rob_src1_byp_slot  = 4'($urandom_range(0, 15));
    @(posedge clk);
    #1;
    if (fill_ok) begin
      filled[fs]   = 1'b1;
      mem_data[fs] = fd;
    end
    if (a && exp_rdy) begin
      exp_q.push_back({m_tail, p});
      filled[m_tail] = 1'b0;
      m_tail = m_tail + 4'd1;
    end
    rob_if.rob_alloc_req_val = 1'b0;
    rob_if.rob_fill_val      = 1'b0;
  endtask

  task automatic pick_fill(output bit f, output logic [3:0] s);
    logic [3:0] cand[$];
    int r;
    f = 1'b0;
    s = '0;
    for (int i = 0; i < exp_q.size(); i++)
      if (!filled[exp_q[i][8:5]]) cand.push_back(exp_q[i][8:5]);
    r = $urandom_range(0, 9);
    if (r < 6 && cand.size() > 0) begin
      f = 1'b1;
      s = cand[$urandom_range(0, cand.size() - 1)];
    end else if (r < 8) begin
      for (int t = 0; t < 16; t++) begin
        logic [3:0] c;
        c = 4'($urandom_range(0, 15));
        if (!in_q(c) && c != m_tail) begin
          f = 1'b1;
          s = c;
          break;
        end
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) begin
      bit f;
      logic [3:0] s;
      f = 1'b0;
      s = '0;
      for (int k = 0; k < exp_q.size(); k++)
        if (!filled[exp_q[k][8:5]]) begin
          f = 1'b1;
          s = exp_q[k][8:5];
          break;
        end
      step(1'b0, 5'd0, f, s, $urandom());
    end
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy"},    {31'd0, rob_if.rob_alloc_req_rdy},   32'd0);
    chk({tag, "_wen"},    {31'd0, rob_if.rob_commit_wen},      32'd0);
    chk({tag, "_resp"},   {28'd0, rob_if.rob_alloc_resp_slot}, 32'd0);
    chk({tag, "_cslot"},  {28'd0, rob_if.rob_commit_slot},     32'd0);
    chk({tag, "_waddr"},  {27'd0, rob_if.rob_commit_rf_waddr}, 32'd0);
    chk({tag, "_wdata"},  rob_if.rob_commit_rf_wdata,          32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("release_rdy", {31'd0, rob_if.rob_alloc_req_rdy}, 32'd1);
    mon_en = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    rob_if.rob_alloc_req_val  = 1'b0;
    rob_if.rob_alloc_req_preg = '0;
    rob_if.rob_fill_val       = 1'b0;
    rob_if.rob_fill_slot      = '0;
    rob_if.rob_fill_data      = '0;
    rob_if.rob_src0_byp_slot  = '0;
    rob_if.rob_src1_byp_slot  = '0;
    model_reset();
    #3;
    check_reset_outputs("por");
    @(posedge clk);
    release_reset();

    // single alloc/fill/commit
    step(1'b1, 5'd5, 1'b0, 4'd0, 32'd0);
    step(1'b0, 5'd0, 1'b1, 4'd0, 32'hDEADBEEF);
    repeat (3) step(1'b0, 5'd0, 1'b0, 4'd0, 32'd0);

    // out-of-order fills, in-order commits
    step(1'b1, 5'd1, 1'b0, 4'd0, 32'd0);
    step(1'b1, 5'd2, 1'b0, 4'd0, 32'd0);
    step(1'b1, 5'd3, 1'b0, 4'd0, 32'd0);
    step(1'b0, 5'd0, 1'b1, exp_q[2][8:5], 32'h2222_0002);
    step(1'b0, 5'd0, 1'b1, exp_q[1][8:5], 32'h1111_0001);
    step(1'b0, 5'd0, 1'b1, exp_q[0][8:5], 32'h0000_0000);
    repeat (4) step(1'b0, 5'd0, 1'b0, 4'd0, 32'd0);

    // fill to full, refused allocs at full, wrap
    repeat (16) step(1'b1, 5'($urandom_range(0, 31)), 1'b0, 4'd0, 32'd0);
    step(1'b1, 5'd7, 1'b0, 4'd0, 32'd0);
    step(1'b1, 5'd7, 1'b1, exp_q[0][8:5], 32'hA5A5_0000);
    step(1'b1, 5'd8, 1'b0, 4'd0, 32'd0);
    step(1'b1, 5'd9, 1'b0, 4'd0, 32'd0);
    drain();

    // steady alloc+commit stream
    for (int i = 0; i < 40; i++) begin
      bit f;
      logic [3:0] s;
      f = (exp_q.size() > 0) && !filled[exp_q[exp_q.size() - 1][8:5]];
      s = f ? exp_q[exp_q.size() - 1][8:5] : 4'd0;
      step(1'b1, 5'($urandom_range(0, 31)), f, s, $urandom());
    end
    drain();

    // reset mid-stream with six live entries
    repeat (6) step(1'b1, 5'($urandom_range(1, 31)), 1'b0, 4'd0, 32'd0);
    step(1'b0, 5'd0, 1'b1, exp_q[3][8:5], 32'h0BAD_0BAD);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("mid");
    model_reset();
    release_reset();

    // bypass of slot 4: old value on the fill cycle, new value after
    repeat (5) step(1'b1, 5'($urandom_range(1, 31)), 1'b0, 4'd0, 32'd0, 4);
    step(1'b0, 5'd0, 1'b1, 4'd4, 32'h0000_1234, 4);
    step(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4);
    chk("byp4_after", rob_if.rob_src0_byp_data, 32'h0000_1234);
    drain();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit f;
      logic [3:0] s;
      pick_fill(f, s);
      step($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), f, s, $urandom());
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
